// File: rtl/ability_cooldown_bank_if.sv
// Signal bundle between the ability cooldown bank and its controller.
// Handshake: the master raises trigger[i] as a level. The bank consumes a rising edge only when
// channel i holds a charge and hold is low, and answers with exactly one fired[i] pulse. There is no backpressure.
interface ability_cooldown_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 7,
  parameter int CHG_W  = 2
);
  logic                    enableDC;
  logic                    hold;
  logic [NUM_CH-1:0]       trigger;
  logic [2:0]              sel;
  logic [NUM_CH-1:0]       ready;
  logic [NUM_CH-1:0]       fired;
  logic [NUM_CH*CHG_W-1:0] charges;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [3:0]              disp_tens;
  logic [3:0]              disp_ones;
  logic                    disp_blank;

  modport master (
    output enableDC, hold, trigger, sel,
    input  ready, fired, charges, count, disp_tens, disp_ones, disp_blank
  );

  modport slave (
    input  enableDC, hold, trigger, sel,
    output ready, fired, charges, count, disp_tens, disp_ones, disp_blank
  );
endinterface

// File: rtl/ability_cooldown_bank.sv
// NUM_CH independent ability cooldown channels with stackable charges, edge-detected triggers,
// a global freeze, and a registered BCD readout of one selected channel's countdown.
module ability_cooldown_bank #(
  parameter int                      NUM_CH      = 4,
  parameter int                      CNT_W       = 7,
  parameter logic [NUM_CH*CNT_W-1:0] CD_VALUES   = {7'd30, 7'd7, 7'd7, 7'd7},
  parameter int                      MAX_CHARGES = 1,
  parameter int                      CHG_W       = 2
) (
  input logic                     clk,
  input logic                     resetn,
  ability_cooldown_bank_if.slave  bus
);

  localparam logic [CHG_W-1:0] MAX_C = CHG_W'(MAX_CHARGES);

  logic [NUM_CH-1:0] trigQ;
  logic [NUM_CH-1:0] firedQ;
  logic [CHG_W-1:0]  chgQ [NUM_CH];
  logic [CHG_W-1:0]  chgD [NUM_CH];
  logic [CNT_W-1:0]  cntQ [NUM_CH];
  logic [CNT_W-1:0]  cntD [NUM_CH];
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] tickOn;
  logic [NUM_CH-1:0] done;
  logic [3:0]        tensQ;
  logic [3:0]        onesQ;
  logic              blankQ;
  logic [CNT_W-1:0]  selCnt;
  logic              selValid;

  // A fire and a recharge completion in the same cycle cancel in charges; the reload still happens
  // because the resulting charge count stays below the maximum.
  always_comb begin
    fire   = '0;
    tickOn = '0;
    done   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i]   = bus.trigger[i] & ~trigQ[i] & (chgQ[i] != '0) & ~bus.hold;
      tickOn[i] = bus.enableDC & ~bus.hold & (cntQ[i] != '0);
      done[i]   = tickOn[i] & (cntQ[i] == CNT_W'(1));
      chgD[i]   = chgQ[i] - CHG_W'(fire[i]) + CHG_W'(done[i]);
      cntD[i]   = cntQ[i];
      if (done[i]) begin
        cntD[i] = (chgD[i] < MAX_C) ? CD_VALUES[i*CNT_W +: CNT_W] : '0;
      end else if (tickOn[i]) begin
        cntD[i] = cntQ[i] - CNT_W'(1);
      end else if (fire[i] && (chgQ[i] == MAX_C)) begin
        cntD[i] = CD_VALUES[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    selCnt   = '0;
    selValid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.sel) == i) begin
        selCnt   = cntQ[i];
        selValid = 1'b1;
      end
    end
  end

  // Trigger history resets to ones so a button held through reset must be released before it fires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trigQ  <= '1;
      firedQ <= '0;
      tensQ  <= '0;
      onesQ  <= '0;
      blankQ <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        chgQ[i] <= MAX_C;
        cntQ[i] <= '0;
      end
    end else begin
      trigQ  <= bus.trigger;
      firedQ <= fire;
      tensQ  <= 4'(selCnt / CNT_W'(10));
      onesQ  <= 4'(selCnt % CNT_W'(10));
      blankQ <= ~selValid | (selCnt == '0);
      for (int i = 0; i < NUM_CH; i++) begin
        chgQ[i] <= chgD[i];
        cntQ[i] <= cntD[i];
      end
    end
  end

  always_comb begin
    bus.ready   = '0;
    bus.charges = '0;
    bus.count   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ready[i]                    = (chgQ[i] != '0);
      bus.charges[i*CHG_W +: CHG_W]   = chgQ[i];
      bus.count[i*CNT_W +: CNT_W]     = cntQ[i];
    end
    bus.fired      = firedQ;
    bus.disp_tens  = tensQ;
    bus.disp_ones  = onesQ;
    bus.disp_blank = blankQ;
  end

endmodule

// File: tb/tb_ability_cooldown_bank.sv
// Bench for ability_cooldown_bank: a single-charge instance and a two-charge instance share one
// stimulus stream and are checked against a behavioural model of the cooldown rules.
module tb_ability_cooldown_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 7;
  localparam int CHG_W  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic       enableDC;
  logic       hold;
  logic [3:0] trigger;
  logic [2:0] sel;

  ability_cooldown_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CHG_W(CHG_W)) if0 ();
  ability_cooldown_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CHG_W(CHG_W)) if1 ();

  assign if0.enableDC = enableDC;
  assign if0.hold     = hold;
  assign if0.trigger  = trigger;
  assign if0.sel      = sel;
  assign if1.enableDC = enableDC;
  assign if1.hold     = hold;
  assign if1.trigger  = trigger;
  assign if1.sel      = sel;

  ability_cooldown_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CD_VALUES({7'd30, 7'd7, 7'd7, 7'd7}),
    .MAX_CHARGES(1), .CHG_W(CHG_W)
  ) u_dut0 (.clk(clk), .resetn(resetn), .bus(if0.slave));

  ability_cooldown_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CD_VALUES({7'd3, 7'd3, 7'd3, 7'd3}),
    .MAX_CHARGES(2), .CHG_W(CHG_W)
  ) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  int m_chg [2][4];
  int m_cnt [2][4];
  bit m_fired [2][4];
  bit m_trq [4];
  int m_tens [2];
  int m_ones [2];
  bit m_blank [2];

  function automatic int cd_of(int d, int i);
    if (d == 1) return 3;
    return (i == 3) ? 30 : 7;
  endfunction

  function automatic int max_of(int d);
    return (d == 1) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_chg[d][i] = max_of(d);
        m_cnt[d][i] = 0;
        m_fired[d][i] = 1'b0;
      end
      m_tens[d] = 0; m_ones[d] = 0; m_blank[d] = 1'b1;
    end
    for (int i = 0; i < 4; i++) m_trq[i] = 1'b1;
  endtask

  // Timer view: whenever a channel is missing a charge its timer runs; when it expires a charge
  // returns, and if a charge is still missing the timer starts over.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int v;
      if (sel < 4) begin
        v = m_cnt[d][sel];
        m_tens[d] = v / 10; m_ones[d] = v % 10; m_blank[d] = (v == 0);
      end else begin
        m_tens[d] = 0; m_ones[d] = 0; m_blank[d] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        bit f;
        f = trigger[i] && !m_trq[i] && (m_chg[d][i] > 0) && !hold;
        if (!hold && enableDC && m_chg[d][i] < max_of(d)) begin
          m_cnt[d][i] = m_cnt[d][i] - 1;
          if (m_cnt[d][i] == 0) m_chg[d][i] = m_chg[d][i] + 1;
        end
        if (f) m_chg[d][i] = m_chg[d][i] - 1;
        if (m_chg[d][i] < max_of(d) && m_cnt[d][i] == 0) m_cnt[d][i] = cd_of(d, i);
        m_fired[d][i] = f;
      end
    end
    for (int i = 0; i < 4; i++) m_trq[i] = trigger[i];
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
  endtask

  function automatic int d_chg(int d, int i);
    return (d == 0) ? int'(if0.charges[i*CHG_W +: CHG_W]) : int'(if1.charges[i*CHG_W +: CHG_W]);
  endfunction
  function automatic int d_cnt(int d, int i);
    return (d == 0) ? int'(if0.count[i*CNT_W +: CNT_W]) : int'(if1.count[i*CNT_W +: CNT_W]);
  endfunction
  function automatic logic d_fired(int d, int i);
    return (d == 0) ? if0.fired[i] : if1.fired[i];
  endfunction
  function automatic logic d_ready(int d, int i);
    return (d == 0) ? if0.ready[i] : if1.ready[i];
  endfunction

  task automatic test_reset();
    trigger = 4'b0001; enableDC = 1'b0; hold = 1'b0; sel = 3'd0;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (d_chg(d, i) !== max_of(d) || d_cnt(d, i) !== 0 || d_fired(d, i) !== 1'b0 || d_ready(d, i) !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_state d%0d ch%0d: chg=%0d cnt=%0d fired=%b ready=%b, want chg=%0d cnt=0 fired=0 ready=1",
                   d, i, d_chg(d, i), d_cnt(d, i), d_fired(d, i), d_ready(d, i), max_of(d));
        end
      end
    end
    n_tests++;
    if (if0.disp_blank !== 1'b1 || if0.disp_tens !== 4'd0 || if0.disp_ones !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_disp: blank=%b tens=%0d ones=%0d, want 1 0 0", if0.disp_blank, if0.disp_tens, if0.disp_ones);
    end
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (if0.fired !== 4'b0000 || if1.fired !== 4'b0000) begin
        n_fail++;
        $display("FAIL held_through_reset cyc%0d: fired0=%b fired1=%b, want 0000", k, if0.fired, if1.fired);
      end
    end
    trigger = 4'b0000; step();
    trigger = 4'b0001; step();
    n_tests++;
    if (if0.fired !== 4'b0001 || d_chg(0, 0) !== 0 || d_cnt(0, 0) !== 7 || if0.ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fire d0: fired=%b chg=%0d cnt=%0d ready=%b, want 0001 0 7 0",
               if0.fired, d_chg(0, 0), d_cnt(0, 0), if0.ready[0]);
    end
    n_tests++;
    if (if1.fired !== 4'b0001 || d_chg(1, 0) !== 1 || d_cnt(1, 0) !== 3 || if1.ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_fire d1: fired=%b chg=%0d cnt=%0d ready=%b, want 0001 1 3 1",
               if1.fired, d_chg(1, 0), d_cnt(1, 0), if1.ready[0]);
    end
    trigger = 4'b0000; step();
    n_tests++;
    if (if0.fired !== 4'b0000) begin
      n_fail++;
      $display("FAIL fired_one_cycle: fired=%b, want 0000", if0.fired);
    end
  endtask

  task automatic test_countdown();
    for (int k = 1; k <= 7; k++) begin
      enableDC = 1'b1; step(); enableDC = 1'b0;
      n_tests++;
      if (d_cnt(0, 0) !== 7 - k || d_chg(0, 0) !== ((k == 7) ? 1 : 0) || if0.ready[0] !== (k == 7)) begin
        n_fail++;
        $display("FAIL countdown tick%0d: cnt=%0d chg=%0d ready=%b, want cnt=%0d chg=%0d",
                 k, d_cnt(0, 0), d_chg(0, 0), if0.ready[0], 7 - k, (k == 7) ? 1 : 0);
      end
      if (k == 3) begin
        trigger = 4'b0001; step(); trigger = 4'b0000;
        n_tests++;
        if (if0.fired[0] !== 1'b0 || d_chg(0, 0) !== 0 || d_cnt(0, 0) !== 4) begin
          n_fail++;
          $display("FAIL press_no_charge: fired=%b chg=%0d cnt=%0d, want 0 0 4", if0.fired[0], d_chg(0, 0), d_cnt(0, 0));
        end
        step();
      end
    end
  endtask

  task automatic test_max2();
    for (int k = 0; k < 20 && m_chg[1][0] != 2; k++) begin
      enableDC = 1'b1; step(); enableDC = 1'b0;
    end
    n_tests++;
    if (d_chg(1, 0) !== 2 || d_cnt(1, 0) !== 0) begin
      n_fail++;
      $display("FAIL max2_full: chg=%0d cnt=%0d, want 2 0", d_chg(1, 0), d_cnt(1, 0));
    end
    trigger = 4'b0001; step();
    n_tests++;
    if (d_chg(1, 0) !== 1 || d_cnt(1, 0) !== 3 || if1.fired[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL max2_fire1: chg=%0d cnt=%0d fired=%b, want 1 3 1", d_chg(1, 0), d_cnt(1, 0), if1.fired[0]);
    end
    trigger = 4'b0000; enableDC = 1'b1; step(); enableDC = 1'b0;
    trigger = 4'b0001; step(); trigger = 4'b0000;
    n_tests++;
    if (d_chg(1, 0) !== 0 || d_cnt(1, 0) !== 2 || if1.fired[0] !== 1'b1 || if1.ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL max2_fire2_no_restart: chg=%0d cnt=%0d fired=%b ready=%b, want 0 2 1 0",
               d_chg(1, 0), d_cnt(1, 0), if1.fired[0], if1.ready[0]);
    end
    enableDC = 1'b1; step(); step(); enableDC = 1'b0;
    n_tests++;
    if (d_chg(1, 0) !== 1 || d_cnt(1, 0) !== 3) begin
      n_fail++;
      $display("FAIL max2_reload: chg=%0d cnt=%0d, want 1 3", d_chg(1, 0), d_cnt(1, 0));
    end
    enableDC = 1'b1; step(); step(); step(); enableDC = 1'b0;
    n_tests++;
    if (d_chg(1, 0) !== 2 || d_cnt(1, 0) !== 0) begin
      n_fail++;
      $display("FAIL max2_refilled: chg=%0d cnt=%0d, want 2 0", d_chg(1, 0), d_cnt(1, 0));
    end
  endtask

  task automatic test_simultaneous();
    trigger = 4'b0001; step(); trigger = 4'b0000;
    enableDC = 1'b1; step(); step();
    n_tests++;
    if (d_chg(1, 0) !== 1 || d_cnt(1, 0) !== 1) begin
      n_fail++;
      $display("FAIL simul_setup: chg=%0d cnt=%0d, want 1 1", d_chg(1, 0), d_cnt(1, 0));
    end
    trigger = 4'b0001; step(); enableDC = 1'b0; trigger = 4'b0000;
    n_tests++;
    if (d_chg(1, 0) !== 1 || d_cnt(1, 0) !== 3 || if1.fired[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_fire_and_done: chg=%0d cnt=%0d fired=%b, want 1 3 1", d_chg(1, 0), d_cnt(1, 0), if1.fired[0]);
    end
    step();
    n_tests++;
    if (if1.fired[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_single_pulse: fired=%b, want 0", if1.fired[0]);
    end
  endtask

  task automatic test_hold();
    trigger = 4'b1000; step(); trigger = 4'b0000;
    n_tests++;
    if (d_cnt(0, 3) !== 30 || if0.fired[3] !== 1'b1 || d_chg(0, 3) !== 0) begin
      n_fail++;
      $display("FAIL hold_setup: cnt3=%0d fired3=%b chg3=%0d, want 30 1 0", d_cnt(0, 3), if0.fired[3], d_chg(0, 3));
    end
    hold = 1'b1; enableDC = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) trigger = 4'b0100;
      step();
      n_tests++;
      if (d_cnt(0, 3) !== 30 || if0.fired !== 4'b0000 || d_chg(0, 2) !== 1 || if0.ready[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_frozen k%0d: cnt3=%0d fired=%b chg2=%0d ready2=%b, want 30 0000 1 1",
                 k, d_cnt(0, 3), if0.fired, d_chg(0, 2), if0.ready[2]);
      end
    end
    hold = 1'b0; enableDC = 1'b0; step();
    n_tests++;
    if (if0.fired[2] !== 1'b0 || d_chg(0, 2) !== 1) begin
      n_fail++;
      $display("FAIL hold_edge_lost: fired2=%b chg2=%0d, want 0 1", if0.fired[2], d_chg(0, 2));
    end
    trigger = 4'b0000; step();
    trigger = 4'b0100; step(); trigger = 4'b0000;
    n_tests++;
    if (if0.fired[2] !== 1'b1 || d_chg(0, 2) !== 0 || d_cnt(0, 2) !== 7) begin
      n_fail++;
      $display("FAIL after_hold_fire: fired2=%b chg2=%0d cnt2=%0d, want 1 0 7", if0.fired[2], d_chg(0, 2), d_cnt(0, 2));
    end
  endtask

  task automatic test_display();
    enableDC = 1'b1; step(); step(); step(); enableDC = 1'b0;
    sel = 3'd3; step();
    n_tests++;
    if (d_cnt(0, 3) !== 27 || if0.disp_tens !== 4'd2 || if0.disp_ones !== 4'd7 || if0.disp_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_27: cnt3=%0d tens=%0d ones=%0d blank=%b, want 27 2 7 0",
               d_cnt(0, 3), if0.disp_tens, if0.disp_ones, if0.disp_blank);
    end
    sel = 3'd5; step();
    n_tests++;
    if (if0.disp_blank !== 1'b1 || if1.disp_blank !== 1'b1) begin
      n_fail++;
      $display("FAIL disp_sel_out_of_range: blank0=%b blank1=%b, want 1 1", if0.disp_blank, if1.disp_blank);
    end
  endtask

  task automatic test_midreset();
    trigger = 4'b0000; step();
    trigger = 4'b1111; sel = 3'd3;
    @(posedge clk);
    model_step();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (if0.fired !== 4'b0000 || if1.fired !== 4'b0000 || if0.ready !== 4'b1111 || if0.count !== '0 ||
        if1.count !== '0 || if0.charges !== 8'b01010101 || if1.charges !== 8'b10101010 || if0.disp_blank !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: fired0=%b fired1=%b ready0=%b cnt0=%h cnt1=%h chg0=%b chg1=%b blank=%b",
               if0.fired, if1.fired, if0.ready, if0.count, if1.count, if0.charges, if1.charges, if0.disp_blank);
    end
    trigger = 4'b0000;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      trigger  = 4'($urandom_range(0, 15));
      enableDC = ($urandom_range(0, 2) == 0);
      hold     = ($urandom_range(0, 9) == 0);
      sel      = 3'($urandom_range(0, 7));
      step();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          n_tests++;
          if (d_chg(d, i) !== m_chg[d][i] || d_cnt(d, i) !== m_cnt[d][i] || d_fired(d, i) !== m_fired[d][i] ||
              d_ready(d, i) !== (m_chg[d][i] != 0)) begin
            n_fail++;
            if (n_fail < 20)
              $display("FAIL random k%0d d%0d ch%0d: chg=%0d cnt=%0d fired=%b ready=%b, want chg=%0d cnt=%0d fired=%b",
                       k, d, i, d_chg(d, i), d_cnt(d, i), d_fired(d, i), d_ready(d, i), m_chg[d][i], m_cnt[d][i], m_fired[d][i]);
          end
          n_tests++;
          if (d_cnt(d, i) == 0 && d_chg(d, i) < max_of(d)) begin
            n_fail++;
            if (n_fail < 20) $display("FAIL idle_timer k%0d d%0d ch%0d: cnt=0 chg=%0d, want chg=%0d", k, d, i, d_chg(d, i), max_of(d));
          end
        end
        n_tests++;
        if ((d == 0 ? if0.disp_tens : if1.disp_tens) !== 4'(m_tens[d]) ||
            (d == 0 ? if0.disp_ones : if1.disp_ones) !== 4'(m_ones[d]) ||
            (d == 0 ? if0.disp_blank : if1.disp_blank) !== m_blank[d]) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL random_disp k%0d d%0d: tens=%0d ones=%0d blank=%b, want %0d %0d %b", k, d,
                                    (d == 0 ? if0.disp_tens : if1.disp_tens), (d == 0 ? if0.disp_ones : if1.disp_ones),
                                    (d == 0 ? if0.disp_blank : if1.disp_blank), m_tens[d], m_ones[d], m_blank[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_max2();
    test_simultaneous();
    test_hold();
    test_display();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ability_cooldown_bank.md
Name: ability_cooldown_bank

Overview:
Parametrised multi-channel ability cooldown manager for the computer character. It generalises the single-ability gate and blackout cooldown timers into NUM_CH independent channels. Each channel has a configurable cooldown length, stackable charges, edge-detected triggers and a global freeze. A selectable channel's remaining time is presented as registered BCD digits for the existing HEX decoders.

Parameters:
NUM_CH, 4, number of independent ability channels (1..8)
CNT_W, 7, cooldown counter width; the maximum cooldown length is 99
CD_VALUES, {7'd30,7'd7,7'd7,7'd7}, packed NUM_CH*CNT_W cooldown lengths in ticks; channel i uses slice [i*CNT_W +: CNT_W]; each value must be 1..99
MAX_CHARGES, 1, charges a channel can bank (1..3); 1 reproduces single-use behaviour
CHG_W, 2, charge counter width

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
enableDC  input  1  one-cycle tick strobe (1 Hz divider output); counters decrement only on it
hold  input  1  global freeze: no decrement, no firing
trigger  input  NUM_CH  raw ability buttons, synchronous to clk, active-high
sel  input  3  channel whose count is displayed
ready  output  NUM_CH  channel has at least one charge
fired  output  NUM_CH  one-cycle pulse when an ability is consumed
charges  output  NUM_CH*CHG_W  current charge count per channel
count  output  NUM_CH*CNT_W  remaining ticks of the current recharge per channel
disp_tens  output  4  BCD tens of count[sel]
disp_ones  output  4  BCD ones of count[sel]
disp_blank  output  1  high when count[sel]==0 or sel>=NUM_CH

Behaviour:
- Reset (async assert, sync release):
  - charges=MAX_CHARGES, count=0, fired=0, ready=all ones.
  - disp_tens=0, disp_ones=0, disp_blank=1.
  - trig_q (trigger history) = all ones, so a button held through reset does not fire until it is released and pressed again.
- Edge detect, per channel: edge[i] = trigger[i] & ~trig_q[i]. trig_q updates every cycle, including while hold=1, so edges that occur during hold are lost.
- Fire condition: fire[i] = edge[i] & (charges[i]!=0) & ~hold.
  - On fire, charges decrements and fired[i]=1 on the next cycle only.
  - An edge with zero charges is ignored; fired stays 0 and nothing is queued.
- Recharge, per channel; the timer runs only while charges<MAX_CHARGES.
  - A fire from charges==MAX_CHARGES loads count=CD_VALUE[i] in the same edge as the decrement.
  - On enableDC & ~hold with count>1: count-1.
  - On enableDC & ~hold with count==1: charges+1. If the resulting charges is still below MAX_CHARGES, reload count=CD_VALUE[i]; otherwise count=0.
  - A fire while count is running does not restart or alter the countdown.
- Simultaneous fire and recharge completion in one cycle:
  - Net charges is unchanged.
  - count reloads CD_VALUE[i], because charges is still below MAX_CHARGES.
  - fired pulses.
- count==0 with charges<MAX_CHARGES is unreachable; the bench asserts this.
- hold=1: count and charges are frozen; fired is forced 0 on the next cycle; ready keeps tracking charges.
- ready[i] is combinational: charges[i]!=0.
- Display path, 1-cycle latency:
  - On every clk edge, register count[sel] split into tens = value/10 and ones = value%10. Both are 0..9 because CD_VALUE<=99.
  - disp_blank is registered alongside.
  - A change of sel is visible on the next cycle.
- Channels are fully independent. Any number of channels may fire in the same cycle.
- Reset asserted mid-countdown clears to the reset state immediately. Pending fired pulses are cancelled.
- Widths: all arithmetic is unsigned. charges never exceeds MAX_CHARGES and never underflows. count never underflows.

Test Plan:
- Reset with trigger[0] held high, then release resetn and keep it held for 5 cycles -> fired=0. Release then press -> fired[0] pulses exactly one cycle, charges[0]=0, count[0]=7, ready[0]=0.
- Fire ch0 (CD=7, MAX_CHARGES=1) and apply 7 enableDC strobes -> count steps 7,6,...,1,0. charges=1 and ready=1 after the 7th strobe; a press before that produces no fired pulse.
- MAX_CHARGES=2, CD=3: fire twice, 1 cycle apart -> charges 2,1,0 and count=3, not restarted by the second fire. Three ticks -> charges=1, count reloads to 3. Three more ticks -> charges=2, count=0.
- MAX_CHARGES=2: fire on the same cycle as the count==1 tick -> charges stays 1, count=3, fired pulses once.
- hold=1 for 10 ticks with ch3 at count=30 -> count stays 30; a press during hold never fires, and a press after hold is dropped fires normally.
- sel=3 with count[3]=27 -> next cycle disp_tens=2, disp_ones=7, disp_blank=0. sel=5 with NUM_CH=4 -> disp_blank=1. Assert resetn mid-countdown -> all channels return to the reset values.
